seg7_value_display: RTL and testbench

SEG7_VALUE_DISPLAY -- requirements
Module: seg7_value_display

---
 rtl/seg7_value_display.sv | 132 +++++++++++++
 tb/tb_seg7_value_display.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/seg7_value_display.sv
// seg7_value_display
// Converts a 7-bit binary value to three decimal digits with a serial
// double-dabble and shows them on active-low seven-segment outputs
// (bit order gfedcba). Leading zeros are blanked. A second counter reports
// when the displayed value has stayed unchanged for STABLE_CYCLES cycles.
module seg7_value_display #(
  parameter int unsigned STABLE_CYCLES = 50000000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [6:0] i_value,
  output logic [6:0] o_seg_hund,
  output logic [6:0] o_seg_tens,
  output logic [6:0] o_seg_ones,
  output logic       o_busy,
  output logic       o_stable
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [31:0] STABLE_MAX = 32'(STABLE_CYCLES);
  localparam logic [6:0]  SEG_BLANK  = 7'b1111111;
  localparam logic [6:0]  SEG_ZERO   = 7'b1000000;

  state_t      state_reg;
  logic [6:0]  r_last;
  // [18:15] hundreds, [14:11] tens, [10:7] ones, [6:0] binary still to shift in
  logic [18:0] shift_reg;
  logic [2:0]  count_reg;
  logic [31:0] stable_cnt_reg;

  logic [18:0] adjusted;
  logic [31:0] stable_cnt_next;
  logic [3:0]  hund_digit;
  logic [3:0]  tens_digit;
  logic [3:0]  ones_digit;

  // Double-dabble correction: every BCD nibble of 5 or more gets +3 before the shift
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_dabble
      logic [3:0] nib;
      assign nib = shift_reg[7 + 4*gi +: 4];
      assign adjusted[7 + 4*gi +: 4] = (nib >= 4'd5) ? (nib + 4'd3) : nib;
    end
  endgenerate
  assign adjusted[6:0] = shift_reg[6:0];

  assign hund_digit = shift_reg[18:15];
  assign tens_digit = shift_reg[14:11];
  assign ones_digit = shift_reg[10:7];

  // Saturating increment of the stability counter
  assign stable_cnt_next = (stable_cnt_reg >= STABLE_MAX) ? STABLE_MAX
                                                          : (stable_cnt_reg + 32'd1);

  function automatic logic [6:0] seg_encode(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = 7'b1111111;
    endcase
    return seg;
  endfunction

  // Conversion FSM, stability tracking and registered display outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg      <= IDLE;
      r_last         <= 7'd0;
      shift_reg      <= 19'd0;
      count_reg      <= 3'd0;
      stable_cnt_reg <= 32'd0;
      o_busy         <= 1'b0;
      o_stable       <= 1'b0;
      o_seg_hund     <= SEG_BLANK;
      o_seg_tens     <= SEG_BLANK;
      o_seg_ones     <= SEG_ZERO;
    end else begin
      case (state_reg)
        IDLE: begin
          if (i_value != r_last) begin
            // Load edge: capture the new value and start converting
            r_last         <= i_value;
            shift_reg      <= {12'd0, i_value};
            count_reg      <= 3'd0;
            stable_cnt_reg <= 32'd0;
            o_stable       <= 1'b0;
            o_busy         <= 1'b1;
            state_reg      <= SHIFT;
          end else begin
            // Display unchanged: advance the stability counter
            stable_cnt_reg <= stable_cnt_next;
            o_stable       <= (stable_cnt_next == STABLE_MAX);
          end
        end
        SHIFT: begin
          shift_reg <= {adjusted[17:0], 1'b0};
          count_reg <= count_reg + 3'd1;
          if (count_reg == 3'd6) begin
            state_reg <= DONE;
          end
        end
        DONE: begin
          o_seg_hund <= (hund_digit == 4'd0) ? SEG_BLANK : seg_encode(hund_digit);
          o_seg_tens <= ((hund_digit == 4'd0) && (tens_digit == 4'd0))
                        ? SEG_BLANK : seg_encode(tens_digit);
          o_seg_ones <= seg_encode(ones_digit);
          o_busy     <= 1'b0;
          state_reg  <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
          o_busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_value_display.sv
// Testbench for seg7_value_display: directed scenarios followed by random
// values, holds and resets, all checked every cycle against a behavioural model.
module tb_seg7_value_display;

  localparam int STABLE = 4;

  logic       i_clk;
  logic       i_rst;
  logic [6:0] i_value;
  logic [6:0] o_seg_hund;
  logic [6:0] o_seg_tens;
  logic [6:0] o_seg_ones;
  logic       o_busy;
  logic       o_stable;

  seg7_value_display #(.STABLE_CYCLES(STABLE)) dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_value   (i_value),
    .o_seg_hund(o_seg_hund),
    .o_seg_tens(o_seg_tens),
    .o_seg_ones(o_seg_ones),
    .o_busy    (o_busy),
    .o_stable  (o_stable)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int vectors;
  int miscompares;

  // Reference model state
  int m_last;
  int m_disp;
  int m_conv;
  int m_busy_left;
  int m_scnt;
  bit m_stable;
  logic [6:0] seg_tab [10];

  task automatic check(input string tag, input int observed, input int expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic logic [6:0] exp_hund(input int v);
    return (v / 100 == 0) ? 7'b1111111 : seg_tab[v / 100];
  endfunction

  function automatic logic [6:0] exp_tens(input int v);
    return (v < 10) ? 7'b1111111 : seg_tab[(v / 10) % 10];
  endfunction

  function automatic logic [6:0] exp_ones(input int v);
    return seg_tab[v % 10];
  endfunction

  // Apply one cycle of stimulus, advance the model, compare all outputs
  task automatic step(input int v, input bit r);
    i_value = 7'(v);
    i_rst   = r;
    @(posedge i_clk);
    if (r) begin
      m_last = 0; m_disp = 0; m_conv = 0; m_busy_left = 0;
      m_scnt = 0; m_stable = 0;
    end else if (m_busy_left > 0) begin
      m_busy_left--;
      if (m_busy_left == 0) begin
        m_disp = m_conv;
        $display("display updated to %0d at %0t", m_disp, $time);
      end
    end else if (v != m_last) begin
      m_last = v; m_conv = v; m_busy_left = 8;
      m_scnt = 0; m_stable = 0;
    end else begin
      if (m_scnt < STABLE) m_scnt++;
      m_stable = (m_scnt == STABLE);
    end
    #1;
    check("hund",   int'(o_seg_hund), int'(exp_hund(m_disp)));
    check("tens",   int'(o_seg_tens), int'(exp_tens(m_disp)));
    check("ones",   int'(o_seg_ones), int'(exp_ones(m_disp)));
    check("busy",   int'(o_busy),     int'(m_busy_left > 0));
    check("stable", int'(o_stable),   int'(m_stable));
  endtask

  task automatic hold(input int v, input int n);
    for (int i = 0; i < n; i++) step(v, 1'b0);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001; seg_tab[2] = 7'b0100100;
    seg_tab[3] = 7'b0110000; seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
    seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000; seg_tab[8] = 7'b0000000;
    seg_tab[9] = 7'b0010000;
    m_last = 0; m_disp = 0; m_conv = 0; m_busy_left = 0; m_scnt = 0; m_stable = 0;
    i_value = 7'd0;
    i_rst   = 1'b1;

    // Reset and idle at zero
    step(0, 1'b1);
    step(0, 1'b1);
    hold(0, 20);
    check("rst_ones", int'(o_seg_ones), 'h40);
    check("rst_tens", int'(o_seg_tens), 'h7f);

    // 42 right after reset, busy for 8 cycles then displayed
    step(0, 1'b1);
    step(42, 1'b0);
    for (int i = 0; i < 7; i++) step(42, 1'b0);
    check("busy_8th", int'(o_busy), 1);
    step(42, 1'b0);
    check("dir42_busy", int'(o_busy), 0);
    check("dir42_hund", int'(o_seg_hund), 'h7f);
    check("dir42_tens", int'(o_seg_tens), 'h19);
    check("dir42_ones", int'(o_seg_ones), 'h24);
    hold(42, 6);

    // Change to 7 drops o_stable on the load edge
    hold(7, 12);
    check("dir7_ones", int'(o_seg_ones), 'h78);

    hold(127, 12);
    check("dir127_hund", int'(o_seg_hund), 'h79);
    check("dir127_tens", int'(o_seg_tens), 'h24);
    check("dir127_ones", int'(o_seg_ones), 'h78);
    hold(100, 12);
    check("dir100_hund", int'(o_seg_hund), 'h79);
    check("dir100_tens", int'(o_seg_tens), 'h40);
    check("dir100_ones", int'(o_seg_ones), 'h40);

    // Input change mid-conversion: 42 shown first, then 5
    step(42, 1'b0);
    hold(42, 3);
    hold(5, 20);
    check("dir5_ones", int'(o_seg_ones), 'h12);
    check("dir5_tens", int'(o_seg_tens), 'h7f);

    // Reset during a conversion of 99
    step(99, 1'b0);
    hold(99, 3);
    step(99, 1'b1);
    check("rst99_busy", int'(o_busy), 0);
    hold(0, 12);

    // Random values, hold lengths and occasional resets
    for (int t = 0; t < 250; t++) begin
      int v;
      int n;
      v = ($urandom_range(0, 3) == 0) ? m_last : int'($urandom_range(0, 127));
      n = int'($urandom_range(1, 14));
      if ($urandom_range(0, 19) == 0) begin
        step(v, 1'b1);
      end
      hold(v, n);
    end
    hold(int'(m_last), 15);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
